// File: rtl/rv32i_fetch_if.sv
// Fetch-stage bus: instruction-memory req/ack channel, PC redirect from branch
// resolution, and the instruction slot presented to decode.
//   master (fetch stage): drives imem_req/imem_addr and ins/ins_pc/ins_valid;
//                         samples imem_ack/imem_rdata, redirect/redirect_pc, stall.
//   slave  (environment): the mirror image (memory + decode + branch unit).
interface rv32i_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        ins_valid;

  modport master (
    output imem_req, imem_addr, ins, ins_pc, ins_valid,
    input  imem_ack, imem_rdata, redirect, redirect_pc, stall
  );

  modport slave (
    input  imem_req, imem_addr, ins, ins_pc, ins_valid,
    output imem_ack, imem_rdata, redirect, redirect_pc, stall
  );
endinterface

// File: rtl/rv32i_fetch.sv
// Instruction fetch stage of the rv32i core.
// Holds the PC, issues word fetches over a req/ack handshake, and presents each
// fetched word with its PC to decode. Redirects replace the PC; a request that
// is already outstanding when a redirect arrives is waited out and its data
// dropped, since the handshake does not allow withdrawing a raised request.
// Ports:
//   clk_i   system clock, rising edge
//   rst_ni  asynchronous active-low reset
//   bus     rv32i_fetch_if.master (imem req/ack, redirect, stall, ins slot)
module rv32i_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic           clk_i,
  input logic           rst_ni,
  rv32i_fetch_if.master bus
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] stale_addr_q, stale_addr_d;
  logic        pending_q, pending_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] ins_pc_q, ins_pc_d;
  logic        ins_valid_q, ins_valid_d;

  logic        req;
  logic [31:0] addr;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = bus.redirect_pc & ~32'h3;

  // Request outputs: only state, pending, ins_valid and stall feed these.
  always_comb begin
    req  = 1'b0;
    addr = pc_q;
    unique case (state_q)
      StIdle:  req = 1'b0;
      // Keep an issued request up; otherwise do not fetch over a stalled slot.
      StFetch: req = pending_q | ~(ins_valid_q & bus.stall);
      StDrain: begin
        req  = 1'b1;
        addr = stale_addr_q;
      end
      default: req = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    stale_addr_d = stale_addr_q;
    pending_d    = pending_q;
    ins_d        = ins_q;
    ins_pc_d     = ins_pc_q;
    ins_valid_d  = ins_valid_q;

    // Decode takes the slot; refilled below if a transfer lands this cycle.
    if (ins_valid_q && !bus.stall) begin
      ins_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
        if (bus.redirect) begin
          pc_d        = redirect_tgt;
          ins_valid_d = 1'b0;
        end
      end
      StFetch: begin
        if (bus.redirect) begin
          ins_valid_d = 1'b0;
          pc_d        = redirect_tgt;
          if (req && !bus.imem_ack) begin
            stale_addr_d = addr;
            pending_d    = 1'b1;
            state_d      = StDrain;
          end else begin
            pending_d = 1'b0;
          end
        end else if (req && bus.imem_ack) begin
          ins_d       = bus.imem_rdata;
          ins_pc_d    = pc_q;
          ins_valid_d = 1'b1;
          pc_d        = pc_q + 32'd4;
          pending_d   = 1'b0;
        end else if (req) begin
          pending_d = 1'b1;
        end
      end
      StDrain: begin
        if (bus.redirect) begin
          pc_d = redirect_tgt;
        end
        if (bus.imem_ack) begin
          pending_d = 1'b0;
          state_d   = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      stale_addr_q <= 32'h0;
      pending_q    <= 1'b0;
      ins_q        <= Nop;
      ins_pc_q     <= 32'h0;
      ins_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      stale_addr_q <= stale_addr_d;
      pending_q    <= pending_d;
      ins_q        <= ins_d;
      ins_pc_q     <= ins_pc_d;
      ins_valid_q  <= ins_valid_d;
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = addr;
  assign bus.ins       = ins_q;
  assign bus.ins_pc    = ins_pc_q;
  assign bus.ins_valid = ins_valid_q;

endmodule

// File: tb/tb_rv32i_fetch.sv
// Testbench for rv32i_fetch: directed timing checks followed by a randomized
// phase scored against an instruction-stream model (sequential PCs, redirect
// targets, memory contents = address + 0x100).
module tb_rv32i_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk;
  logic rst_ni;

  rv32i_fetch_if bus ();

  rv32i_fetch #(
    .RESET_PC(RESET_PC)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Memory model: fixed latency (ack once a request has waited lat cycles) or
  // a random per-cycle ack in random mode.
  int unsigned lat;
  bit          rnd_mode;
  bit          rnd_ok;
  int unsigned wcnt;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a + 32'h100;
  endfunction

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) wcnt <= 0;
    else if (bus.imem_req && !bus.imem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always_comb begin
    bus.imem_ack   = bus.imem_req && (rnd_mode ? rnd_ok : (wcnt >= lat));
    bus.imem_rdata = mem(bus.imem_addr);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, {31'b0, bus.imem_req}, 32'd0);
    chk({tag, "_addr"}, bus.imem_addr, RESET_PC);
    chk({tag, "_ins"}, bus.ins, 32'h0000_0013);
    chk({tag, "_ins_pc"}, bus.ins_pc, 32'h0);
    chk({tag, "_valid"}, {31'b0, bus.ins_valid}, 32'd0);
  endtask

  task automatic chk_slot(input string tag, input logic v, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'b0, bus.ins_valid}, {31'b0, v});
    if (v) begin
      chk({tag, "_ins_pc"}, bus.ins_pc, pc);
      chk({tag, "_ins"}, bus.ins, mem(pc));
    end
  endtask

  task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
    chk({tag, "_req"}, {31'b0, bus.imem_req}, {31'b0, r});
    if (r) chk({tag, "_addr"}, bus.imem_addr, a);
  endtask

  // Random-phase model state
  logic [31:0] exp_next;
  logic [31:0] held_pc;
  int          delivered;
  logic        p_req, p_ack, p_valid, p_stall, p_redir;
  logic [31:0] p_addr, p_tgt;

  initial begin
    rst_ni          = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.stall       = 1'b0;
    lat             = 0;
    rnd_mode        = 1'b0;
    rnd_ok          = 1'b0;

    repeat (2) tick();
    chk_reset("rst");

    // Zero-wait memory: IDLE, then one fetch per cycle.
    rst_ni = 1'b1;
    #1;
    chk_req("c0", 1'b0, 32'h0);
    tick();
    chk_req("c1", 1'b1, 32'h0);
    chk_slot("c1", 1'b0, 32'h0);
    tick();
    chk_slot("c2", 1'b1, 32'h0);
    tick();
    chk_slot("c3", 1'b1, 32'h4);
    tick();
    chk_slot("c4", 1'b1, 32'h8);

    // Stall three cycles at 0x8.
    bus.stall = 1'b1;
    #1;
    chk_req("stall0", 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_slot("stall_hold", 1'b1, 32'h8);
      chk_req("stall_hold", 1'b0, 32'h0);
    end
    bus.stall = 1'b0;
    #1;
    chk_req("resume", 1'b1, 32'hC);
    tick();
    chk_slot("resume", 1'b1, 32'hC);

    // Two-cycle latency; redirect to 0x40 while 0x10 is pending.
    lat = 2;
    #1;
    chk_req("lat_issue", 1'b1, 32'h10);
    tick();
    chk_slot("lat_pend", 1'b0, 32'h0);
    chk_req("lat_pend", 1'b1, 32'h10);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h40;
    #1;
    tick();
    bus.redirect = 1'b0;
    chk_slot("drain", 1'b0, 32'h0);
    chk_req("drain", 1'b1, 32'h10);
    tick();
    chk_slot("post_drain", 1'b0, 32'h0);
    chk_req("post_drain", 1'b1, 32'h40);
    tick();
    chk_req("w40a", 1'b1, 32'h40);
    tick();
    chk_req("w40b", 1'b1, 32'h40);
    tick();
    chk_slot("got40", 1'b1, 32'h40);

    // Redirects while draining: 0x600 enters DRAIN, then 0x40, then 0x80.
    lat             = 3;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h600;
    #1;
    chk_req("d_in", 1'b1, 32'h44);
    tick();
    bus.redirect_pc = 32'h40;
    chk_slot("d1", 1'b0, 32'h0);
    chk_req("d1", 1'b1, 32'h44);
    tick();
    bus.redirect_pc = 32'h80;
    chk_req("d2", 1'b1, 32'h44);
    tick();
    bus.redirect = 1'b0;
    chk_req("d3", 1'b1, 32'h44);
    tick();
    chk_req("d_out", 1'b1, 32'h80);
    chk_slot("d_out", 1'b0, 32'h0);
    lat = 0;
    #1;
    tick();
    chk_slot("got80", 1'b1, 32'h80);

    // Redirect to 0x203 coinciding with ack and stall.
    lat = 1;
    #1;
    chk_req("r2_issue", 1'b1, 32'h84);
    tick();
    chk_slot("r2_pend", 1'b0, 32'h0);
    bus.stall       = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h203;
    #1;
    chk_req("r2_ack", 1'b1, 32'h84);
    tick();
    bus.redirect = 1'b0;
    chk_slot("r2_drop", 1'b0, 32'h0);
    chk_req("r2_tgt", 1'b1, 32'h200);
    bus.stall = 1'b0;
    lat       = 0;
    #1;
    tick();
    chk_slot("got200", 1'b1, 32'h200);

    // PC wrap at 0xFFFF_FFFC, then reset mid-request.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    #1;
    tick();
    bus.redirect = 1'b0;
    chk_req("wrap_issue", 1'b1, 32'hFFFF_FFFC);
    tick();
    chk_slot("wrap_got", 1'b1, 32'hFFFF_FFFC);
    chk_req("wrap_next", 1'b1, 32'h0);
    lat = 2;
    #1;
    tick();
    chk_req("wrap_pend", 1'b1, 32'h0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_reset("midrst");

    // Randomized phase.
    tick();
    rnd_mode  = 1'b1;
    rst_ni    = 1'b1;
    exp_next  = RESET_PC;
    held_pc   = RESET_PC;
    delivered = 0;
    for (int i = 0; i < 1200; i++) begin
      bus.stall       = ($urandom_range(0, 3) == 0);
      bus.redirect    = ($urandom_range(0, 9) == 0);
      bus.redirect_pc = $urandom;
      rnd_ok          = ($urandom_range(0, 2) != 0);
      #1;
      p_req   = bus.imem_req;
      p_ack   = bus.imem_ack;
      p_addr  = bus.imem_addr;
      p_valid = bus.ins_valid;
      p_stall = bus.stall;
      p_redir = bus.redirect;
      p_tgt   = bus.redirect_pc;
      tick();

      if (p_req && !p_ack) begin
        chk("rnd_req_held", {31'b0, bus.imem_req}, 32'd1);
        chk("rnd_addr_stable", bus.imem_addr, p_addr);
      end
      if (p_redir) begin
        chk("rnd_redir_valid", {31'b0, bus.ins_valid}, 32'd0);
        exp_next = {p_tgt[31:2], 2'b00};
      end else if (p_valid && p_stall) begin
        chk("rnd_hold_valid", {31'b0, bus.ins_valid}, 32'd1);
        chk("rnd_hold_pc", bus.ins_pc, held_pc);
        chk("rnd_hold_ins", bus.ins, mem(held_pc));
      end else if (bus.ins_valid) begin
        chk("rnd_seq_pc", bus.ins_pc, exp_next);
        chk("rnd_seq_ins", bus.ins, mem(exp_next));
        held_pc  = exp_next;
        exp_next = exp_next + 32'd4;
        delivered++;
      end

      if (i == 600) begin
        bus.redirect = 1'b0;
        rst_ni       = 1'b0;
        #1;
        chk_reset("rnd_rst");
        tick();
        rst_ni   = 1'b1;
        exp_next = RESET_PC;
        held_pc  = RESET_PC;
      end
    end
    bus.redirect = 1'b0;
    chk("rnd_delivered", (delivered >= 100) ? 32'd1 : 32'd0, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
